// File: rtl/npc_pkg.sv
// Shared encodings for the fetch-stage next-PC controller: branch opcodes,
// FSM states and default reset/exception addresses.
package npc_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } npc_state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_br_cmp.sv
// Branch condition resolver for the six MIPS compare-branch ops (signed 32-bit).
module npc_br_cmp
  import npc_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        taken
);

  logic rs_zero;
  assign rs_zero = (rs == 32'd0);

  always_comb begin
    case (br_op)
      BR_BEQ:  taken = (rs == rt);
      BR_BNE:  taken = (rs != rt);
      BR_BLEZ: taken = rs[31] | rs_zero;
      BR_BGTZ: taken = ~rs[31] & ~rs_zero;
      BR_BLTZ: taken = rs[31];
      BR_BGEZ: taken = ~rs[31];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_fetch_ctrl.sv
// Fetch-stage PC register and next-PC select with redirect capture across stalls.
// Define NPC_EXC_EN to activate the exception / eret redirect inputs.
module npc_fetch_ctrl
  import npc_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] pc_d_i,
  input  logic [2:0]        br_op_i,
  input  logic [31:0]       rs_val_i,
  input  logic [31:0]       rt_val_i,
  input  logic [15:0]       imm16_i,
  input  logic              j_valid_i,
  input  logic [25:0]       jidx_i,
  input  logic              jr_valid_i,
  input  logic              exc_req_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] npc_o,
  output logic              redir_o,
  output logic              pend_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];

  npc_state_t        state;
  logic [ADDR_W-1:0] pc_q, pend_q;
  logic              exc, eret, taken;

`ifdef NPC_EXC_EN
  assign exc  = exc_req_i;
  assign eret = eret_i;
`else
  logic unused_exc;
  assign unused_exc = ^{exc_req_i, eret_i, epc_i};
  assign exc  = 1'b0;
  assign eret = 1'b0;
`endif

  npc_br_cmp u_br_cmp (
    .br_op (br_op_i),
    .rs    (rs_val_i),
    .rt    (rt_val_i),
    .taken (taken)
  );

  logic [ADDR_W-1:0] seq, pc_d4, br_off, br_tgt, j_tgt, jr_tgt, eret_tgt;
  logic [31:0]       pc_d4_w, j_w;

  assign seq      = pc_q + ADDR_W'(4);
  assign pc_d4    = pc_d_i + ADDR_W'(4);
  assign br_off   = ADDR_W'({{14{imm16_i[15]}}, imm16_i, 2'b00});
  assign br_tgt   = pc_d4 + br_off;
  assign pc_d4_w  = 32'(pc_d4);
  assign j_w      = {pc_d4_w[31:28], jidx_i, 2'b00};
  assign j_tgt    = j_w[ADDR_W-1:0];
  assign jr_tgt   = {rs_val_i[ADDR_W-1:2], 2'b00};
  assign eret_tgt = {epc_i[ADDR_W-1:2], 2'b00};

  // Highest-priority request this cycle; tgt falls back to seq when none.
  logic              req, mis;
  logic [ADDR_W-1:0] tgt;
  always_comb begin
    req = 1'b1;
    mis = 1'b0;
    tgt = seq;
    if (exc)             tgt = EXC_PC;
    else if (eret)       begin tgt = eret_tgt; mis = |epc_i[1:0];    end
    else if (jr_valid_i) begin tgt = jr_tgt;   mis = |rs_val_i[1:0]; end
    else if (j_valid_i)  tgt = j_tgt;
    else if (taken)      tgt = br_tgt;
    else                 req = 1'b0;
  end

  // While pending, D repeats the same instruction, so only exc may retarget.
  always_comb begin
    npc_o      = pc_q;
    redir_o    = 1'b0;
    misalign_o = 1'b0;
    if (state == ST_RUN) begin
      redir_o    = req;
      misalign_o = req & mis;
      if (!stall_i) npc_o = tgt;
    end else if (!stall_i) begin
      npc_o   = exc ? EXC_PC : pend_q;
      redir_o = 1'b1;
    end else begin
      redir_o = exc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RST_PC;
      pend_q <= '0;
      state  <= ST_RUN;
    end else begin
      pc_q <= npc_o;
      case (state)
        ST_RUN:
          if (stall_i && req) begin
            pend_q <= tgt;
            state  <= ST_PEND;
          end
        ST_PEND:
          if (!stall_i)  state  <= ST_RUN;
          else if (exc)  pend_q <= EXC_PC;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign pc_o   = pc_q;
  assign pend_o = (state == ST_PEND);

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Scoreboard bench for npc_fetch_ctrl: directed scenarios plus random traffic
// against a behavioural next-PC model.
module tb_npc_fetch_ctrl;

`ifdef NPC_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] EXV = 32'h0000_4180;

  logic        clk = 1'b0, reset;
  logic        stall_i, j_valid_i, jr_valid_i, exc_req_i, eret_i;
  logic [31:0] pc_d_i, rs_val_i, rt_val_i, epc_i;
  logic [2:0]  br_op_i;
  logic [15:0] imm16_i;
  logic [25:0] jidx_i;
  logic [31:0] pc_o, npc_o;
  logic        redir_o, pend_o, misalign_o;

  npc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .pc_d_i(pc_d_i),
    .br_op_i(br_op_i), .rs_val_i(rs_val_i), .rt_val_i(rt_val_i),
    .imm16_i(imm16_i), .j_valid_i(j_valid_i), .jidx_i(jidx_i),
    .jr_valid_i(jr_valid_i), .exc_req_i(exc_req_i), .eret_i(eret_i),
    .epc_i(epc_i), .pc_o(pc_o), .npc_o(npc_o), .redir_o(redir_o),
    .pend_o(pend_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, npc;
    bit          redir, pend, mis;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0;
  logic [31:0] m_pc, m_tgt;
  bit          m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit br_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    case (op)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return $signed(rs) <= 0;
      3'd4: return $signed(rs) > 0;
      3'd5: return $signed(rs) < 0;
      3'd6: return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    stall_i = 0; j_valid_i = 0; jr_valid_i = 0; exc_req_i = 0; eret_i = 0;
    pc_d_i = 32'h3010; br_op_i = 0; rs_val_i = 0; rt_val_i = 0;
    imm16_i = 0; jidx_i = 0; epc_i = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance one edge.
  task automatic cyc();
    exp_t        e;
    bit          has, mis, ex, pend_n;
    logic [31:0] t, tgt_n;
    has = 1; mis = 0; t = 0;
    ex = EXC_EN && exc_req_i;
    if (ex)                    t = EXV;
    else if (EXC_EN && eret_i) begin t = epc_i & ~32'h3;    mis = epc_i[1:0] != 0; end
    else if (jr_valid_i)       begin t = rs_val_i & ~32'h3; mis = rs_val_i[1:0] != 0; end
    else if (j_valid_i)        t = ((pc_d_i + 4) & 32'hF000_0000) | (32'(jidx_i) * 4);
    else if (br_taken(br_op_i, rs_val_i, rt_val_i))
      t = pc_d_i + 4 + 32'(int'($signed(imm16_i)) * 4);
    else has = 0;
    pend_n = m_pend; tgt_n = m_tgt;
    e.pc = m_pc; e.pend = m_pend; e.mis = 0; e.redir = 0;
    if (!m_pend) begin
      e.redir = has;
      e.mis   = has && mis;
      e.npc   = stall_i ? m_pc : (has ? t : m_pc + 4);
      if (stall_i && has) begin pend_n = 1; tgt_n = t; end
    end else if (!stall_i) begin
      e.npc = ex ? EXV : m_tgt; e.redir = 1; pend_n = 0;
    end else begin
      e.npc = m_pc; e.redir = ex;
      if (ex) tgt_n = EXV;
    end
    q.push_back(e);
    @(posedge clk); #1;
    m_pc = e.npc; m_pend = pend_n; m_tgt = tgt_n;
  endtask

  always @(negedge clk) begin
    if (!reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("npc_o", npc_o, e.npc);
      chk("redir_o", 32'(redir_o), 32'(e.redir));
      chk("pend_o", 32'(pend_o), 32'(e.pend));
      chk("misalign_o", 32'(misalign_o), 32'(e.mis));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    m_pc = RST; m_pend = 0; m_tgt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_pc", pc_o, RST);
    chk("reset_pend", 32'(pend_o), 0);
    chk("reset_mis", 32'(misalign_o), 0);

    repeat (3) cyc();
    chk("seq_300c", pc_o, 32'h300C);

    // beq taken, then bne not taken with the same operands
    br_op_i = 3'd1; rs_val_i = 5; rt_val_i = 5; imm16_i = 16'h0003; pc_d_i = 32'h3010;
    #1 chk("beq_npc", npc_o, 32'h3020); chk("beq_redir", 32'(redir_o), 1);
    cyc();
    br_op_i = 3'd2;
    #1 chk("bne_npc", npc_o, m_pc + 4); chk("bne_redir", 32'(redir_o), 0);
    cyc();

    // bltz taken with negative offset; bgtz on zero not taken
    br_op_i = 3'd5; rs_val_i = 32'h8000_0000; imm16_i = 16'hFFFF;
    #1 chk("bltz_npc", npc_o, 32'h3010);
    cyc();
    br_op_i = 3'd4; rs_val_i = 0;
    #1 chk("bgtz_npc", npc_o, m_pc + 4);
    cyc();

    // j during a stall is held pending until release
    idle(); stall_i = 1; j_valid_i = 1; jidx_i = 26'h0000C40;
    repeat (4) cyc();
    chk("stall_pend", 32'(pend_o), 1);
    stall_i = 0;
    cyc();
    chk("release_pc", pc_o, 32'h3100);
    chk("release_pend", 32'(pend_o), 0);

    // jr beats j; misaligned target flagged for exactly one cycle
    idle(); jr_valid_i = 1; rs_val_i = 32'h3007; j_valid_i = 1; jidx_i = 26'h123;
    #1 chk("jr_mis", 32'(misalign_o), 1);
    cyc();
    chk("jr_pc", pc_o, 32'h3004);
    idle();
    #1 chk("jr_mis_clr", 32'(misalign_o), 0);
    cyc();

    // async reset while pending
    stall_i = 1; j_valid_i = 1; jidx_i = 26'h0000C40;
    cyc(); cyc();
    chk("pend_before_rst", 32'(pend_o), 1);
    reset = 1;
    #1 chk("rst_mid_pc", pc_o, RST); chk("rst_mid_pend", 32'(pend_o), 0);
    @(posedge clk); #1 reset = 0;
    idle(); m_pc = RST; m_pend = 0; m_tgt = 0;

    // exception vs taken branch, then eret
    br_op_i = 3'd1; rs_val_i = 1; rt_val_i = 1; imm16_i = 16'h0010; exc_req_i = 1;
    cyc();
    chk("exc_pc", pc_o, EXC_EN ? EXV : 32'h3054);
    idle(); eret_i = 1; epc_i = 32'h3040;
    cyc();
    chk("eret_pc", pc_o, EXC_EN ? 32'h3040 : m_pc);

    // wrap at top of address space
    idle(); jr_valid_i = 1; rs_val_i = 32'hFFFF_FFFC;
    cyc(); idle(); cyc();
    chk("wrap_pc", pc_o, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] pool [5];
      pool[0] = 0; pool[1] = 5; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000; pool[4] = $urandom;
      stall_i    = ($urandom_range(0, 9) < 3);
      pc_d_i     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2)
                                              : 32'h3000 + ($urandom_range(0, 255) << 2);
      br_op_i    = 3'($urandom_range(0, 7));
      rs_val_i   = pool[$urandom_range(0, 4)];
      rt_val_i   = pool[$urandom_range(0, 4)];
      imm16_i    = 16'($urandom);
      j_valid_i  = ($urandom_range(0, 5) == 0);
      jidx_i     = 26'($urandom);
      jr_valid_i = ($urandom_range(0, 6) == 0);
      exc_req_i  = ($urandom_range(0, 15) == 0);
      eret_i     = ($urandom_range(0, 12) == 0);
      epc_i      = 32'h3000 + $urandom_range(0, 1023);
      cyc();
    end
    idle();
    cyc();
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
